// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receiver and transmitter
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_WAIT_IDLE = 3'd0;
    localparam uart_state_t ST_IDLE      = 3'd1;
    localparam uart_state_t ST_START     = 3'd2;
    localparam uart_state_t ST_DATA      = 3'd3;
    localparam uart_state_t ST_STOP      = 3'd4;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word fall-through receive FIFO
// Head entry is presented combinationally; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = DATA_BITS,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    PTR_ONE = 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = pop_i && !w_empty;
    assign w_do_push = push_i && (!w_full || w_do_pop);

    assign valid_o = !w_empty;
    assign full_o  = w_full;
    assign drop_o  = push_i && !w_do_push;
    // Gate the head so the output reads zero whenever nothing is queued.
    assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with FWFT byte FIFO
// rxd is double-synchronised; all sampling decisions use the second flop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    input  logic                 err_clr_i
);

    localparam int                BCW       = $clog2(CLKS_PER_BIT);
    localparam int                BIW       = $clog2(DATA_BITS);
    localparam logic [BCW-1:0]    BAUD_MID  = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0]    BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0]    BAUD_ONE  = 1;
    localparam logic [BIW-1:0]    BIT_LAST  = BIW'(DATA_BITS - 1);
    localparam logic [BIW-1:0]    BIT_ONE   = 1;

    logic                 r_sync1;
    logic                 r_rx_s;
    uart_state_t          r_state;
    logic [BCW-1:0]       r_baud;
    logic [BIW-1:0]       r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_baud_mid;
    logic w_baud_last;
    logic w_push;
    logic w_full;
    logic w_drop;

    assign w_baud_mid  = (r_baud == BAUD_MID);
    assign w_baud_last = (r_baud == BAUD_LAST);
    assign w_push      = (r_state == ST_STOP) && w_baud_last && r_rx_s;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rxd_i;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_WAIT_IDLE;
            r_baud      <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                ST_WAIT_IDLE: begin
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_baud  <= '0;
                    end
                end
                ST_START: begin
                    // A start bit that is high again by mid-bit was only a glitch.
                    if (w_baud_mid) begin
                        r_baud <= '0;
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + BIT_ONE;
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= ST_WAIT_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (err_clr_i) begin
            r_overrun <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .data_i  (r_shift),
        .pop_i   (ready_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .full_o  (w_full),
        .drop_o  (w_drop)
    );

    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and randomized checks of uart_rx against a queue model
module tb_uart_rx;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       rxd     = 1'b1;
    logic       ready   = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int fe_cnt  = 0;
    int fe0;

    logic [7:0] q[$];
    logic       model_ovr;
    logic [7:0] d;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .rxd_i       (rxd),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .err_clr_i   (err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit and 8 data bits, then the stop level for stop_cycles clocks.
    // stop_cycles=6 returns in the cycle whose closing edge takes the stop sample.
    task automatic send_bits(input logic [7:0] b, input logic stop, input int stop_cycles);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop;
        tick(stop_cycles);
    endtask

    // Whole frame followed by idle; the model queues or drops the byte.
    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b1, CPB);
        rxd = 1'b1;
        tick(4);
        if (q.size() < DEPTH) q.push_back(b);
        else model_ovr = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = q.pop_front();
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_data"}, 32'(data), 32'(e));
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
    endtask

    initial begin
        model_ovr = 1'b0;
        tick(3);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick(5);

        // Single byte: valid appears the cycle after the stop sample
        send_bits(8'hA5, 1'b1, 6);
        check("a5_valid_before", 32'(valid), 32'd0);
        tick(1);
        check("a5_valid_after", 32'(valid), 32'd1);
        check("a5_data", 32'(data), 32'hA5);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("a5_popped", 32'(valid), 32'd0);
        tick(4);

        // Short low glitches on an idle line
        for (int len = 1; len <= 2; len++) begin
            fe0 = fe_cnt;
            rxd = 1'b0;
            tick(len);
            rxd = 1'b1;
            tick(20);
            check("glitch_valid", 32'(valid), 32'd0);
            check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
            send_byte(8'($urandom));
            pop_check("glitch_next");
        end

        // Framing error: one-cycle pulse, no byte, recovery after line idles
        fe0 = fe_cnt;
        send_bits(8'h3C, 1'b0, 6);
        check("fe_before", 32'(frame_err), 32'd0);
        tick(1);
        check("fe_pulse", 32'(frame_err), 32'd1);
        tick(1);
        check("fe_after", 32'(frame_err), 32'd0);
        check("fe_no_byte", 32'(valid), 32'd0);
        tick(20);
        check("fe_count", 32'(fe_cnt - fe0), 32'd1);
        rxd = 1'b1;
        tick(10);
        send_byte(8'h11);
        pop_check("fe_recover");

        // Overrun with ready held low
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            check("ovr_flag", 32'(overrun), 32'(model_ovr));
            check("ovr_valid", 32'(valid), 32'(q.size() > 0));
        end
        while (q.size() > 0) pop_check("ovr_read");
        check("ovr_empty", 32'(valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        model_ovr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Push into a full FIFO with a pop on the stop-sample cycle
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        send_bits(8'h05, 1'b1, 6);
        check("fullpop_head", 32'(data), 32'(q[0]));
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        void'(q.pop_front());
        q.push_back(8'h05);
        check("fullpop_no_ovr", 32'(overrun), 32'd0);
        rxd = 1'b1;
        tick(4);
        while (q.size() > 0) pop_check("fullpop_read");
        check("fullpop_empty", 32'(valid), 32'd0);

        // Overrun and clear in the same cycle: set wins
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        d = 8'($urandom);
        send_bits(d, 1'b1, 6);
        check("setwin_before", 32'(overrun), 32'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("setwin_after", 32'(overrun), 32'd1);
        rxd = 1'b1;
        tick(4);
        while (q.size() > 0) pop_check("setwin_read");

        // Reset mid-DATA with bytes queued and overrun still set
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        rxd = 1'b0;
        tick(CPB);
        rxd = 1'b1;
        tick(20);
        rxd = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_fe", 32'(frame_err), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        q.delete();
        model_ovr = 1'b0;
        @(posedge clk);
        tick(2);
        reset = 1'b0;
        tick(100);
        check("lowline_no_byte", 32'(valid), 32'd0);
        rxd = 1'b1;
        tick(10);
        send_byte(8'h7E);
        pop_check("post_rst");
        check("post_rst_empty", 32'(valid), 32'd0);
        check("post_rst_overrun", 32'(overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
